// File: rtl/press_pkg.sv
// press_pkg
// Shared definitions for the button press classifier:
//   - FSM state encoding (plain 3-bit constants)
//   - default hold / double-press window lengths in clk cycles
//   - counter width helper used to size the shared press timer
package press_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PRESS1    = 3'd1;
  localparam state_t ST_LONG_HOLD = 3'd2;
  localparam state_t ST_WAIT2     = 3'd3;
  localparam state_t ST_PRESS2    = 3'd4;

  localparam int DEF_LONG_CYCLES = 1000;
  localparam int DEF_DBL_CYCLES  = 300;

  // The counter only ever reaches max(a,b)-1, so $clog2(max) bits suffice.
  // Never return zero so the counter stays a legal vector.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/press_timer.sv
// press_timer
// Clear/enable up-counter with a terminal-count compare.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count up by one
//   term       : terminal value to compare against
//   cnt        : current count
//   tc         : high while cnt == term
module press_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/press_classifier.sv
// press_classifier
// Classifies a debounced button level into short, long and double presses.
// Parameters:
//   LONG_CYCLES : cycles a press must be held to become a long press (>= 2)
//   DBL_CYCLES  : window after a release in which a re-press makes a double (>= 2)
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_in       : debounced button level, already synchronous to clk
//   short_press  : one-cycle pulse, single press released early with no re-press
//   long_press   : one-cycle pulse, press held for LONG_CYCLES
//   double_press : one-cycle pulse, release of the second press
//   held         : level, high while the long press is still being held
//   event_count  : running count of all pulses, wraps at 256
module press_classifier
  import press_pkg::*;
#(
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int DBL_CYCLES  = DEF_DBL_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [7:0] event_count
);

  localparam int CNT_W = cnt_width(LONG_CYCLES, DBL_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYCLES - 1);

  logic             btn_d;
  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_nxt;
  logic             short_nxt;
  logic             long_nxt;
  logic             dbl_nxt;
  logic             tmr_en;
  logic             tmr_clr;
  logic [CNT_W-1:0] tmr_term;
  logic [CNT_W-1:0] cnt;
  logic             tc;

  // btn_d resets high so a button held through reset looks already pressed:
  // it must be released and pressed again before anything is classified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_d <= 1'b1;
    end else begin
      btn_d <= btn_in;
    end
  end

  assign rise = btn_in & ~btn_d;
  assign fall = ~btn_in & btn_d;

  // The timer only runs while a state is actively timing; in every other
  // case it is held at zero, so each timed state starts from a clean count.
  assign tmr_clr  = ~tmr_en;
  assign tmr_term = (state == ST_WAIT2) ? DBL_TC : LONG_TC;

  press_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    state_nxt = state;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_nxt = ST_WAIT2;
        end else if (tc) begin
          state_nxt = ST_LONG_HOLD;
          long_nxt  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_LONG_HOLD: begin
        // Release after a long press is silent.
        if (fall) state_nxt = ST_IDLE;
      end
      ST_WAIT2: begin
        // A re-press on the timeout edge still counts as a double press.
        if (rise) begin
          state_nxt = ST_PRESS2;
        end else if (tc) begin
          state_nxt = ST_IDLE;
          short_nxt = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_PRESS2: begin
        // Second press may be held indefinitely; only its release matters.
        if (fall) begin
          state_nxt = ST_IDLE;
          dbl_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so each pulse appears
  // in the cycle right after its deciding edge, and event_count moves with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
      event_count  <= 8'd0;
    end else begin
      state        <= state_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= dbl_nxt;
      held         <= (state_nxt == ST_LONG_HOLD);
      if (short_nxt | long_nxt | dbl_nxt) begin
        event_count <= event_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 LONG_CYCLES, default 1000, clk cycles a press must be held to count as a long press; must be >= 2.
REQ-002 DBL_CYCLES, default 300, clk cycles after a release within which a second press makes a double press; must be >= 2.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_in  input  1  debounced button level, synchronous to clk (debounce output); no synchronizer in this block.
REQ-006 short_press  output  1  one-cycle pulse: single press, released before LONG_CYCLES, no re-press within DBL_CYCLES.
REQ-007 long_press  output  1  one-cycle pulse: press held for LONG_CYCLES.
REQ-008 double_press  output  1  one-cycle pulse: second press released after a qualifying gap.
REQ-009 held  output  1  level, high while in LONG_HOLD.
REQ-010 event_count  output  8  count of short+long+double events, wraps 255->0.

Function
REQ-011 Sample register btn_d; rise = btn_in & ~btn_d; fall = ~btn_in & btn_d.
REQ-012 States: IDLE, PRESS1, LONG_HOLD, WAIT2, PRESS2; single counter cnt, width $clog2(max(LONG_CYCLES,DBL_CYCLES)); no overflow possible.
REQ-013 IDLE: rise -> PRESS1, cnt=0.
REQ-014 PRESS1: fall -> WAIT2, cnt=0; else if cnt==LONG_CYCLES-1 -> LONG_HOLD and long_press pulse; else cnt+1.
REQ-015 LONG_HOLD: held=1; fall -> IDLE; no other pulse on release.
REQ-016 WAIT2: rise -> PRESS2; else if cnt==DBL_CYCLES-1 -> IDLE and short_press pulse; else cnt+1.
REQ-017 WAIT2 rise and timeout on the same edge: rise wins, no short_press.
REQ-018 PRESS2: fall -> IDLE and double_press pulse; hold duration in PRESS2 is unbounded and never yields long_press.
REQ-019 All outputs are registered; each pulse is high for exactly one cycle, in the cycle after the deciding edge.
REQ-020 At most one of short_press/long_press/double_press is high in any cycle.
REQ-021 event_count increments in the same cycle any pulse is high.

Reset
REQ-022 rst_n low: state=IDLE, cnt=0, all pulses=0, held=0, event_count=0, btn_d=1.
REQ-023 btn_d=1 means a button held through reset release produces no event until it is released and pressed again.
REQ-024 Reset mid-operation discards the in-progress press with no pulse emitted.

Structure
REQ-025 Shared package press_pkg holds the state encoding and the default LONG_CYCLES/DBL_CYCLES constants.
REQ-026 One sub-module, press_timer (clear/enable/terminal-count counter), supplies cnt; the FSM, edge detect and event_count stay in press_classifier.

Verification (LONG_CYCLES=8, DBL_CYCLES=4)
REQ-027 Short press: btn_in high 3 cycles then low -> short_press high one cycle, 4 clocks after the fall-sampling edge; event_count=1.
REQ-028 Long press: btn_in high 20 cycles -> long_press one cycle, 8 clocks after the rise-sampling edge; held high until release; no short_press; event_count=1.
REQ-029 Double press: high 2, low 2, high 2, low -> double_press one cycle after the second fall; no short_press; event_count=1.
REQ-030 Boundary: second rise sampled on the edge where WAIT2 cnt==3 -> PRESS2, then double_press on release; short_press never asserted.
REQ-031 Reset: rst_n low during PRESS1 with btn_in high, released with btn_in still high -> all outputs 0, no pulse until btn_in low then high again.
REQ-032 Wrap: 256 short presses -> event_count reads 0 after the 256th pulse.
